// File: rtl/srambank_param_bwe.sv
`default_nettype none
// ============================================================================
//  Module   : srambank_param_bwe
//  Summary  : Parametrised synchronous SRAM bank with per-lane write enables,
//             1- or 2-cycle read latency with a valid strobe, a built-in
//             zero-fill sequencer and a read/write collision flag.
//  Revision : 1.0 - initial release
// ============================================================================
module srambank_param_bwe #(
    parameter int WIDTH         = 72,
    parameter int LANE_W        = 8,
    parameter int DEPTH         = 1024,
    parameter int ADDR_W        = 10,
    parameter int RD_LAT        = 1,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         ADDRESS,
    input  logic [WIDTH-1:0]          wd,
    input  logic [WIDTH/LANE_W-1:0]   wmask,
    input  logic                      banksel,
    input  logic                      read,
    input  logic                      write,
    input  logic                      init_req,
    output logic [WIDTH-1:0]          dataout,
    output logic                      dout_valid,
    output logic                      init_busy,
    output logic                      collision
);

    localparam int                NLANES    = WIDTH / LANE_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_FILL  = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                init_busy_q;
    logic [WIDTH-1:0]    dataout_q;
    logic                dout_valid_q;
    logic                collision_q;

    logic [WIDTH-1:0]    mem_q [DEPTH];

    logic                w_ready;
    logic                w_in_range;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_coll;
    logic [WIDTH-1:0]    w_rd_word;
    logic                w_pipe_valid;
    logic [WIDTH-1:0]    w_pipe_data;

    // Accesses are only honoured while the bank is not zero-filling; write wins over read.
    assign w_ready    = (state_q == ST_READY);
    assign w_in_range = ({1'b0, ADDRESS} < DEPTH_EXT);
    assign w_wr_acc   = w_ready & banksel & write & w_in_range;
    assign w_rd_acc   = w_ready & banksel & read & ~write;
    assign w_coll     = w_ready & banksel & read & write;

    // Out-of-range reads return zero rather than an aliased word.
    assign w_rd_word  = w_in_range ? mem_q[ADDRESS] : '0;

    // Fill sequencer: walks cnt 0..DEPTH-1, leaving on the edge that writes the last word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT_ON_RESET ? ST_FILL : ST_READY;
            cnt_q       <= '0;
            init_busy_q <= INIT_ON_RESET;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (init_req) begin
                        state_q     <= ST_FILL;
                        init_busy_q <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                ST_FILL: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q     <= ST_READY;
                        init_busy_q <= 1'b0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage array: not reset; fill writes zero, otherwise masked lane writes.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == ST_FILL) begin
                mem_q[cnt_q] <= '0;
            end else if (w_wr_acc) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (wmask[i]) begin
                        mem_q[ADDRESS][i*LANE_W +: LANE_W] <= wd[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] stage_data_q;
            logic             stage_valid_q;

            // Extra array-read register; an in-flight read survives the start of a fill.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage_valid_q <= 1'b0;
                    stage_data_q  <= '0;
                end else begin
                    stage_valid_q <= w_rd_acc;
                    if (w_rd_acc) begin
                        stage_data_q <= w_rd_word;
                    end
                end
            end

            assign w_pipe_valid = stage_valid_q;
            assign w_pipe_data  = stage_data_q;
        end else begin : g_lat1
            assign w_pipe_valid = w_rd_acc;
            assign w_pipe_data  = w_rd_word;
        end
    endgenerate

    // Output stage: dataout holds between reads; valid and collision are 1-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataout_q    <= '0;
            dout_valid_q <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            dout_valid_q <= w_pipe_valid;
            collision_q  <= w_coll;
            if (w_pipe_valid) begin
                dataout_q <= w_pipe_data;
            end
        end
    end

    assign dataout    = dataout_q;
    assign dout_valid = dout_valid_q;
    assign init_busy  = init_busy_q;
    assign collision  = collision_q;

endmodule
`default_nettype wire

// File: tb/tb_srambank_param_bwe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srambank_param_bwe
//  Summary  : Scoreboard bench for srambank_param_bwe. Instance A uses the
//             default parameters; instance B uses RD_LAT=2, DEPTH=1000 and
//             no automatic fill.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_srambank_param_bwe;

    typedef struct {
        int          cyc;
        logic [71:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit saw_coll = 1'b0;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A signals
    logic        a_rst_n, a_bs, a_rd, a_wr, a_init;
    logic [9:0]  a_addr;
    logic [71:0] a_wd;
    logic [8:0]  a_m;
    logic [71:0] a_dout;
    logic        a_vld, a_busy, a_coll;

    // Instance B signals
    logic        b_rst_n, b_bs, b_rd, b_wr, b_init;
    logic [9:0]  b_addr;
    logic [71:0] b_wd;
    logic [8:0]  b_m;
    logic [71:0] b_dout;
    logic        b_vld, b_busy, b_coll;

    srambank_param_bwe dut_a (
        .clk(clk), .reset_n(a_rst_n), .ADDRESS(a_addr), .wd(a_wd), .wmask(a_m),
        .banksel(a_bs), .read(a_rd), .write(a_wr), .init_req(a_init),
        .dataout(a_dout), .dout_valid(a_vld), .init_busy(a_busy), .collision(a_coll)
    );

    srambank_param_bwe #(
        .WIDTH(72), .LANE_W(8), .DEPTH(1000), .ADDR_W(10), .RD_LAT(2), .INIT_ON_RESET(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(b_rst_n), .ADDRESS(b_addr), .wd(b_wd), .wmask(b_m),
        .banksel(b_bs), .read(b_rd), .write(b_wr), .init_req(b_init),
        .dataout(b_dout), .dout_valid(b_vld), .init_busy(b_busy), .collision(b_coll)
    );

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor A: every valid pulse must match the oldest expected read, at the expected cycle.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_vld === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_valid: got dout_valid=1 data=%h required no pending read", a_dout);
            end else begin
                e = qa.pop_front();
                if (e.cyc != cyc || a_dout !== e.data) begin
                    errors++;
                    $display("FAIL a_read: got %h at cycle %0d required %h at cycle %0d", a_dout, cyc, e.data, e.cyc);
                end
            end
        end
    end

    // Monitor B: same scheme for the two-cycle-latency instance.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_vld === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_valid: got dout_valid=1 data=%h required no pending read", b_dout);
            end else begin
                e = qb.pop_front();
                if (e.cyc != cyc || b_dout !== e.data) begin
                    errors++;
                    $display("FAIL b_read: got %h at cycle %0d required %h at cycle %0d", b_dout, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic a_drive(input logic bs, input logic rd, input logic wr, input logic ini,
                           input logic [9:0] ad, input logic [71:0] d, input logic [8:0] m);
        @(negedge clk);
        a_bs = bs; a_rd = rd; a_wr = wr; a_init = ini; a_addr = ad; a_wd = d; a_m = m;
    endtask

    task automatic a_idle();
        a_drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 72'd0, 9'd0);
    endtask

    task automatic a_write(input logic [9:0] ad, input logic [71:0] d, input logic [8:0] m);
        a_drive(1'b1, 1'b0, 1'b1, 1'b0, ad, d, m);
    endtask

    task automatic a_read(input logic [9:0] ad, input logic [71:0] exp);
        a_drive(1'b1, 1'b1, 1'b0, 1'b0, ad, 72'd0, 9'd0);
        qa.push_back('{cyc + 1, exp});
    endtask

    task automatic b_drive(input logic bs, input logic rd, input logic wr, input logic ini,
                           input logic [9:0] ad, input logic [71:0] d, input logic [8:0] m);
        @(negedge clk);
        b_bs = bs; b_rd = rd; b_wr = wr; b_init = ini; b_addr = ad; b_wd = d; b_m = m;
    endtask

    task automatic b_idle();
        b_drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 72'd0, 9'd0);
    endtask

    task automatic b_write(input logic [9:0] ad, input logic [71:0] d);
        b_drive(1'b1, 1'b0, 1'b1, 1'b0, ad, d, 9'h1FF);
    endtask

    task automatic b_read(input logic [9:0] ad, input logic [71:0] exp);
        b_drive(1'b1, 1'b1, 1'b0, 1'b0, ad, 72'd0, 9'd0);
        qb.push_back('{cyc + 2, exp});
    endtask

    // Counts negedges with init_busy high, starting at the current negedge (bounded).
    // Optionally injects a write+read request to address 10 in the middle of the fill.
    task automatic a_count_busy(input bit inject, output int n);
        n = 0;
        while (a_busy === 1'b1 && n < 5000) begin
            n++;
            if (inject && n == 500) begin
                a_bs = 1'b1; a_rd = 1'b1; a_wr = 1'b1; a_addr = 10'd10; a_wd = 72'hFF; a_m = 9'h1FF;
            end else if (inject && n == 501) begin
                a_bs = 1'b0; a_rd = 1'b0; a_wr = 1'b0;
            end
            if (a_coll === 1'b1) saw_coll = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic b_count_busy(output int n);
        n = 0;
        while (b_busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        a_rst_n = 1'b0; a_bs = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_init = 1'b0;
        a_addr = '0; a_wd = '0; a_m = '0;
        b_rst_n = 1'b0; b_bs = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_init = 1'b0;
        b_addr = '0; b_wd = '0; b_m = '0;

        repeat (3) @(negedge clk);
        chk("a_reset_dout", a_dout, 72'd0);
        chk("a_reset_valid", a_vld, 72'd0);
        chk("a_reset_coll", a_coll, 72'd0);
        chk("a_reset_busy", a_busy, 72'd1);

        // Release reset: automatic fill of 1024 words, with ignored requests in the middle.
        a_rst_n = 1'b1;
        a_count_busy(1'b1, n);
        chk("a_fill_len", n, 72'd1024);
        chk("a_fill_no_coll", saw_coll, 72'd0);

        a_read(10'h3FF, 72'd0);
        a_write(10'd5, 72'h12_3456789A_BCDEF012, 9'h1FF);
        a_write(10'd5, {72{1'b1}}, 9'h001);
        a_read(10'd5, 72'h12_3456789A_BCDEF0FF);
        a_write(10'd5, {72{1'b1}}, 9'h100);
        a_read(10'd5, 72'hFF_3456789A_BCDEF0FF);
        a_write(10'd5, 72'd0, 9'h000);
        a_read(10'd5, 72'hFF_3456789A_BCDEF0FF);
        a_idle();

        // Simultaneous read and write: write lands, read dropped, collision pulses once.
        a_drive(1'b1, 1'b1, 1'b1, 1'b0, 10'd7, 72'h55, 9'h1FF);
        a_idle();
        chk("a_coll_pulse", a_coll, 72'd1);
        chk("a_coll_dout_hold", a_dout, 72'hFF_3456789A_BCDEF0FF);
        a_idle();
        chk("a_coll_once", a_coll, 72'd0);
        a_read(10'd7, 72'h55);
        a_read(10'd10, 72'd0);
        a_read(10'd5, 72'hFF_3456789A_BCDEF0FF);

        // init_req together with a write: write happens, fill starts next cycle.
        a_drive(1'b1, 1'b0, 1'b1, 1'b1, 10'd20, 72'hAB, 9'h1FF);
        a_idle();
        chk("a_init_busy_rise", a_busy, 72'd1);
        repeat (100) @(negedge clk);
        chk("a_dout_before_reset", a_dout, 72'hFF_3456789A_BCDEF0FF);
        #2 a_rst_n = 1'b0;
        #1;
        chk("a_midfill_reset_dout", a_dout, 72'd0);
        chk("a_midfill_reset_busy", a_busy, 72'd1);
        @(negedge clk);
        a_rst_n = 1'b1;
        a_count_busy(1'b0, n);
        chk("a_refill_len", n, 72'd1024);
        a_read(10'd20, 72'd0);
        a_read(10'd5, 72'd0);
        a_idle();
        repeat (3) a_idle();
        chk("a_queue_empty", qa.size(), 72'd0);

        // Instance B: RD_LAT=2, DEPTH=1000, no fill after reset.
        chk("b_reset_dout", b_dout, 72'd0);
        b_rst_n = 1'b1;
        chk("b_reset_busy", b_busy, 72'd0);
        b_write(10'd1, 72'hA);
        b_write(10'd2, 72'hB);
        b_write(10'd3, 72'hC);
        b_read(10'd1, 72'hA);
        b_read(10'd2, 72'hB);
        b_read(10'd3, 72'hC);
        b_idle();
        repeat (5) b_idle();
        chk("b_dout_hold", b_dout, 72'hC);

        b_write(10'd10, 72'h11);
        b_write(10'd986, 72'h33);
        b_write(10'd1010, 72'h77);
        b_read(10'd1010, 72'd0);
        b_read(10'd986, 72'h33);
        b_read(10'd10, 72'h11);
        b_idle();
        repeat (3) b_idle();

        // Read issued together with init_req completes while the fill runs.
        b_drive(1'b1, 1'b1, 1'b0, 1'b1, 10'd2, 72'd0, 9'd0);
        qb.push_back('{cyc + 2, 72'hB});
        b_idle();
        b_count_busy(n);
        chk("b_fill_len", n, 72'd1000);
        b_read(10'd1, 72'd0);
        b_read(10'd1010, 72'd0);
        b_idle();
        repeat (4) b_idle();
        chk("b_queue_empty", qb.size(), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
